// File: rtl/run_detect_pkg.sv
// Shared types and defaults for the run-length detection scheduler.
package run_detect_pkg;

    typedef enum logic [1:0] {
        WAKE  = 2'd0,
        SERVE = 2'd1,
        STALL = 2'd2
    } sched_state_t;

    localparam int unsigned DEF_NCH     = 4;
    localparam int unsigned DEF_RUN_LEN = 4;

    // Width of a run counter that saturates at run_len.
    function automatic int unsigned cnt_w(input int unsigned run_len);
        return $clog2(run_len + 1);
    endfunction

endpackage

// File: rtl/run_chan.sv
// Per-channel run state: last bit value and saturating run count.
module run_chan
    import run_detect_pkg::*;
#(
    parameter int unsigned RUN_LEN = DEF_RUN_LEN
) (
    input  logic clk,
    input  logic nReset,
    input  logic clr,
    input  logic acc,
    input  logic bit_in,
    output logic match,
    output logic done_c
);

    localparam int unsigned CNT_W = cnt_w(RUN_LEN);

    logic             last_q;
    logic             last_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;

    // Next run state; clear wins over an accept so a colliding bit is discarded.
    always_comb begin
        last_nxt = last_q;
        cnt_nxt  = cnt_q;
        done_c   = (cnt_q == CNT_W'(RUN_LEN - 1)) && (last_q == bit_in);
        if (clr) begin
            last_nxt = 1'b0;
            cnt_nxt  = '0;
        end else if (acc) begin
            if ((cnt_q == '0) || (bit_in != last_q)) begin
                last_nxt = bit_in;
                cnt_nxt  = CNT_W'(1);
            end else if (cnt_q != CNT_W'(RUN_LEN)) begin
                cnt_nxt  = cnt_q + CNT_W'(1);
            end
        end
    end

    // Run state and registered match level.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            last_q <= 1'b0;
            cnt_q  <= '0;
            match  <= 1'b0;
        end else begin
            last_q <= last_nxt;
            cnt_q  <= cnt_nxt;
            match  <= (cnt_nxt == CNT_W'(RUN_LEN));
        end
    end

endmodule

// File: rtl/run_detect_sched.sv
// Round-robin scheduler sharing run detection across NCH serial channels.
// Optional: define RUN_DETECT_STATS_EN to add the 16-bit evt_count output.
module run_detect_sched
    import run_detect_pkg::*;
#(
    parameter int unsigned NCH     = DEF_NCH,
    parameter int unsigned RUN_LEN = DEF_RUN_LEN
) (
    input  logic                    clk,
    input  logic                    nReset,
    input  logic [NCH-1:0]          ch_valid,
    input  logic [NCH-1:0]          ch_bit,
    output logic [NCH-1:0]          ch_ready,
    input  logic [NCH-1:0]          clr,
    output logic [NCH-1:0]          match,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [$clog2(NCH)-1:0]  evt_ch,
    output logic                    evt_bit
`ifdef RUN_DETECT_STATS_EN
    ,
    output logic [15:0]             evt_count
`endif
);

    localparam int unsigned IDX_W = $clog2(NCH);

    sched_state_t     state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             gnt_en;
    logic             acc;
    logic             new_evt;
    logic [NCH-1:0]   done_v;
    int unsigned      probe;

    // Grants are held off while a pending event is refused, so it is never overwritten.
    assign gnt_en  = (state_q == SERVE) && (!evt_valid || evt_ready);
    assign acc     = gnt_en && gnt_vld;
    assign new_evt = acc && done_v[gnt_idx] && !clr[gnt_idx];

    // Round-robin search for the first valid channel at or after ptr.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        probe   = 0;
        for (int unsigned k = 0; k < NCH; k++) begin
            probe = (32'(ptr_q) + k) % NCH;
            if (!gnt_vld && ch_valid[IDX_W'(probe)]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'(probe);
            end
        end
    end

    // One-hot ready toward the granted channel.
    always_comb begin
        ch_ready = '0;
        if (acc) begin
            ch_ready[gnt_idx] = 1'b1;
        end
    end

    // Per-channel run detectors.
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        run_chan #(
            .RUN_LEN (RUN_LEN)
        ) u_chan (
            .clk    (clk),
            .nReset (nReset),
            .clr    (clr[i]),
            .acc    (ch_valid[i] & ch_ready[i]),
            .bit_in (ch_bit[i]),
            .match  (match[i]),
            .done_c (done_v[i])
        );
    end

    // Controller: wake for one cycle, then serve or stall on output backpressure.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= WAKE;
        end else begin
            case (state_q)
                WAKE:    state_q <= SERVE;
                SERVE:   if (evt_valid && !evt_ready) state_q <= STALL;
                STALL:   if (evt_ready) state_q <= SERVE;
                default: state_q <= WAKE;
            endcase
        end
    end

    // Round-robin pointer advances past each accepted channel.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            ptr_q <= '0;
        end else if (acc) begin
            ptr_q <= (gnt_idx == IDX_W'(NCH - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    // Single-entry event register; a new event replaces one being handed off.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_bit   <= 1'b0;
        end else if (new_evt) begin
            evt_valid <= 1'b1;
            evt_ch    <= gnt_idx;
            evt_bit   <= ch_bit[gnt_idx];
        end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

`ifdef RUN_DETECT_STATS_EN
    // Count of delivered events, wrapping at 16 bits.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            evt_count <= '0;
        end else if (evt_valid && evt_ready) begin
            evt_count <= evt_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_run_detect_sched.sv
// Randomized and directed bench for run_detect_sched against a behavioural model.
// Honors RUN_DETECT_STATS_EN for the optional evt_count output.
module tb_run_detect_sched;

    localparam int NCH     = 4;
    localparam int RUN_LEN = 4;
    localparam int IW      = 2;

    logic            clk;
    logic            nReset;
    logic [NCH-1:0]  ch_valid;
    logic [NCH-1:0]  ch_bit;
    logic [NCH-1:0]  ch_ready;
    logic [NCH-1:0]  clr;
    logic [NCH-1:0]  match;
    logic            evt_valid;
    logic            evt_ready;
    logic [IW-1:0]   evt_ch;
    logic            evt_bit;
`ifdef RUN_DETECT_STATS_EN
    logic [15:0]     evt_count;
`endif

    run_detect_sched #(
        .NCH     (NCH),
        .RUN_LEN (RUN_LEN)
    ) dut (
        .clk       (clk),
        .nReset    (nReset),
        .ch_valid  (ch_valid),
        .ch_bit    (ch_bit),
        .ch_ready  (ch_ready),
        .clr       (clr),
        .match     (match),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_bit   (evt_bit)
`ifdef RUN_DETECT_STATS_EN
        ,
        .evt_count (evt_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Behavioural model state.
    int m_cnt  [NCH];
    bit m_last [NCH];
    bit m_wake;
    bit m_stall;
    bit m_ev_v;
    int m_ev_ch;
    bit m_ev_b;
    int m_ptr;
    int m_stat;

    // Observations from the most recent cycle.
    logic [NCH-1:0] last_ready;
    bit             last_acc;
    int             obs_evts = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i]  = 0;
            m_last[i] = 1'b0;
        end
        m_wake  = 1'b1;
        m_stall = 1'b0;
        m_ev_v  = 1'b0;
        m_ev_ch = 0;
        m_ev_b  = 1'b0;
        m_ptr   = 0;
        m_stat  = 0;
    endtask

    // Compare one cycle against the model, then advance both across a clock edge.
    task automatic cycle();
        int g;
        int idx;
        bit b;
        bit fire;
        bit hs;
        logic [NCH-1:0] er;
        logic [NCH-1:0] em;
        #1;
        g = -1;
        if (!m_wake && !m_stall && !(m_ev_v && !evt_ready)) begin
            for (int k = 0; k < NCH; k++) begin
                idx = (m_ptr + k) % NCH;
                if (g < 0 && ch_valid[IW'(idx)]) g = idx;
            end
        end
        er = '0;
        if (g >= 0) er[IW'(g)] = 1'b1;
        em = '0;
        for (int i = 0; i < NCH; i++) em[i] = (m_cnt[i] == RUN_LEN);
        chk("ch_ready", 32'(ch_ready), 32'(er));
        chk("match", 32'(match), 32'(em));
        chk("evt_valid", 32'(evt_valid), 32'(m_ev_v));
        if (m_ev_v) begin
            chk("evt_ch", 32'(evt_ch), 32'(m_ev_ch));
            chk("evt_bit", 32'(evt_bit), 32'(m_ev_b));
        end
`ifdef RUN_DETECT_STATS_EN
        chk("evt_count", 32'(evt_count), 32'(m_stat));
`endif
        last_ready = ch_ready;
        last_acc   = (g >= 0);
        if (evt_valid && evt_ready) obs_evts++;

        hs   = m_ev_v && evt_ready;
        fire = 1'b0;
        b    = 1'b0;
        if (g >= 0 && !clr[IW'(g)]) begin
            b = ch_bit[IW'(g)];
            if (m_cnt[g] == 0 || b != m_last[g]) begin
                m_last[g] = b;
                m_cnt[g]  = 1;
            end else begin
                if (m_cnt[g] == RUN_LEN - 1) fire = 1'b1;
                if (m_cnt[g] < RUN_LEN) m_cnt[g]++;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (clr[i]) begin
                m_cnt[i]  = 0;
                m_last[i] = 1'b0;
            end
        end
        if (m_wake)       m_stall = 1'b0;
        else if (m_stall) m_stall = !evt_ready;
        else              m_stall = m_ev_v && !evt_ready;
        m_wake = 1'b0;
        if (fire) begin
            m_ev_v  = 1'b1;
            m_ev_ch = g;
            m_ev_b  = b;
        end else if (hs) begin
            m_ev_v = 1'b0;
        end
        if (hs) m_stat = (m_stat + 1) % 65536;
        if (g >= 0) m_ptr = (g + 1) % NCH;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        #1;
        chk("rst_ready", 32'(ch_ready), 32'h0);
        chk("rst_evt_valid", 32'(evt_valid), 32'h0);
        chk("rst_match", 32'(match), 32'h0);
        chk("rst_evt_ch", 32'(evt_ch), 32'h0);
        chk("rst_evt_bit", 32'(evt_bit), 32'h0);
        @(posedge clk);
        @(negedge clk);
        nReset = 1'b1;
        model_reset();
    endtask

    // Offer one bit on a single channel until it is accepted (bounded).
    task automatic send(input int ch, input bit b, input bit c);
        bit done;
        ch_valid         = '0;
        ch_valid[IW'(ch)] = 1'b1;
        ch_bit[IW'(ch)]   = b;
        clr              = '0;
        clr[IW'(ch)]      = c;
        done = 1'b0;
        for (int n = 0; n < 16 && !done; n++) begin
            cycle();
            done = last_acc;
        end
        if (!done) chk("send_timeout", 32'h0, 32'h1);
        ch_valid = '0;
        clr      = '0;
    endtask

    task automatic idle();
        ch_valid = '0;
        clr      = '0;
        cycle();
    endtask

    task automatic clear_all();
        ch_valid = '0;
        clr      = '1;
        cycle();
        clr      = '0;
        cycle();
    endtask

    initial begin : main
        int ev0;
        bit brk [8];
        logic [NCH-1:0] hold;
        nReset    = 1'b1;
        ch_valid  = '1;
        ch_bit    = '0;
        clr       = '0;
        evt_ready = 1'b1;
        model_reset();
        #2;

        // Reset with all channels requesting, then fairness from ch0.
        do_reset();
        cycle();
        chk("wake_ready", 32'(last_ready), 32'h0);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("fair_grant", 32'(last_ready), 32'(1 << (k % NCH)));
        end

        // Run of zeros on ch0.
        clear_all();
        for (int k = 0; k < 4; k++) send(0, 1'b0, 1'b0);
        chk("zero_evt_valid", 32'(evt_valid), 32'h1);
        chk("zero_evt_ch", 32'(evt_ch), 32'h0);
        chk("zero_evt_bit", 32'(evt_bit), 32'h0);
        chk("zero_match", 32'(match[0]), 32'h1);
        send(0, 1'b0, 1'b0);
        chk("zero5_evt_valid", 32'(evt_valid), 32'h0);
        chk("zero5_match", 32'(match[0]), 32'h1);
        idle();

        // Broken run on ch1.
        brk = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        ev0 = obs_evts;
        for (int k = 0; k < 8; k++) begin
            send(1, brk[k], 1'b0);
            if (k == 3) chk("brk_match4", 32'(match[1]), 32'h0);
        end
        chk("brk_evt_valid", 32'(evt_valid), 32'h1);
        chk("brk_evt_ch", 32'(evt_ch), 32'h1);
        chk("brk_evt_bit", 32'(evt_bit), 32'h1);
        idle();
        chk("brk_evt_count", 32'(obs_evts - ev0), 32'h1);

        // Clear colliding with the completing accept on ch2.
        for (int k = 0; k < 3; k++) send(2, 1'b1, 1'b0);
        send(2, 1'b1, 1'b1);
        chk("clr_evt_valid", 32'(evt_valid), 32'h0);
        chk("clr_match", 32'(match[2]), 32'h0);
        for (int k = 0; k < 4; k++) send(2, 1'b1, 1'b0);
        chk("clr_rerun_valid", 32'(evt_valid), 32'h1);
        chk("clr_rerun_ch", 32'(evt_ch), 32'h2);
        idle();

        // Backpressure on a ch3 event.
        clear_all();
        evt_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(3, 1'b1, 1'b0);
        chk("bp_evt_valid", 32'(evt_valid), 32'h1);
        ch_valid = '1;
        ch_bit   = '0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_ready", 32'(last_ready), 32'h0);
            chk("bp_evt_ch", 32'(evt_ch), 32'h3);
            chk("bp_evt_bit", 32'(evt_bit), 32'h1);
        end
        evt_ready = 1'b1;
        ev0 = obs_evts;
        cycle();
        chk("bp_handshake", 32'(obs_evts - ev0), 32'h1);
        cycle();
        chk("bp_resume", 32'(last_ready), 32'h1);
        idle();

        // Randomized traffic with occasional mid-operation reset.
        hold = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 9) == 0) hold[i] = ~hold[i];
                clr[i] = ($urandom_range(0, 19) == 0);
            end
            ch_bit    = hold;
            ch_valid  = NCH'($urandom);
            evt_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        evt_ready = 1'b1;
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
